// File: rtl/lane_sensor_encoder_if.sv
// Bus between the intersection environment and lane_sensor_encoder.
// Inputs : arr_raw / dep_raw raw detector levels (bit0=NS, bit1=SN, bit2=EW,
//          bit3=WE), light_signal controller code.
// Outputs: per-lane S1/S5 flags, packed queue counts, sticky overflow flags.
// master = environment / testbench side, slave = encoder side.
interface lane_sensor_encoder_if #(
    parameter int CNT_W = 4
);
    logic [3:0]         arr_raw;
    logic [3:0]         dep_raw;
    logic [3:0]         light_signal;
    logic               NS_S1, SN_S1, EW_S1, WE_S1;
    logic               NS_S5, SN_S5, EW_S5, WE_S5;
    logic [4*CNT_W-1:0] queue_cnt;
    logic [3:0]         ovf;

    modport master (
        output arr_raw, dep_raw, light_signal,
        input  NS_S1, SN_S1, EW_S1, WE_S1,
        input  NS_S5, SN_S5, EW_S5, WE_S5,
        input  queue_cnt, ovf
    );

    modport slave (
        input  arr_raw, dep_raw, light_signal,
        output NS_S1, SN_S1, EW_S1, WE_S1,
        output NS_S5, SN_S5, EW_S5, WE_S5,
        output queue_cnt, ovf
    );
endinterface

// File: rtl/lane_sensor_encoder.sv
// Four-lane vehicle queue encoder.
// Each raw arrival/departure detector is synchronized, debounced and turned
// into a one-cycle rising-edge event. Per lane, arrivals increment and
// departures (only while that lane is green) decrement a saturating counter.
// Ports: clk, rst (async, active low), bus (lane_sensor_encoder_if.slave).

// One detector: 2-flop synchronizer, debounce filter, rising-edge event.
module lane_sensor_encoder_deb #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    logic [1:0] sync;
    logic       f;
    logic       f_prev;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '0;
            f      <= 1'b0;
            f_prev <= 1'b0;
            cnt    <= '0;
        end else begin
            sync   <= {sync[0], raw};
            f_prev <= f;
            if (sync[1] == f) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                // level has differed for DEB_CYCLES consecutive cycles
                f   <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign rise = f & ~f_prev;
endmodule

module lane_sensor_encoder #(
    parameter int CNT_W      = 4,
    parameter int EXT_THRESH = 5,
    parameter int DEB_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    lane_sensor_encoder_if.slave  bus
);
    localparam int               LANES = 4;
    localparam logic [CNT_W-1:0] CMAX  = {CNT_W{1'b1}};

    logic [LANES-1:0]            arr_ev;
    logic [LANES-1:0]            dep_ev;
    logic [LANES-1:0][CNT_W-1:0] cnt;
    logic [LANES-1:0]            ovf_r;
    logic [LANES-1:0]            s1;
    logic [LANES-1:0]            s5;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic dep_ok;
        logic inc;
        logic dec;

        lane_sensor_encoder_deb #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.arr_raw[gi]),
            .rise (arr_ev[gi])
        );

        lane_sensor_encoder_deb #(.DEB_CYCLES(DEB_CYCLES)) u_dep (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.dep_raw[gi]),
            .rise (dep_ev[gi])
        );

        // green codes are 1,3,5,7 for lanes 0..3
        assign dep_ok = dep_ev[gi] && (bus.light_signal == 4'(2*gi + 1));
        assign inc    = arr_ev[gi] & ~dep_ok;
        assign dec    = dep_ok & ~arr_ev[gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt[gi]   <= '0;
                ovf_r[gi] <= 1'b0;
            end else if (inc) begin
                if (cnt[gi] == CMAX) ovf_r[gi] <= 1'b1;
                else                 cnt[gi]   <= cnt[gi] + 1'b1;
            end else if (dec) begin
                if (cnt[gi] != '0)   cnt[gi]   <= cnt[gi] - 1'b1;
            end
        end

        assign s1[gi] = (cnt[gi] != '0);
        // widened compare so a threshold above the counter range never fires
        assign s5[gi] = (32'(cnt[gi]) >= 32'(EXT_THRESH));
    end

    assign bus.queue_cnt = cnt;
    assign bus.ovf       = ovf_r;
    assign bus.NS_S1     = s1[0];
    assign bus.SN_S1     = s1[1];
    assign bus.EW_S1     = s1[2];
    assign bus.WE_S1     = s1[3];
    assign bus.NS_S5     = s5[0];
    assign bus.SN_S5     = s5[1];
    assign bus.EW_S5     = s5[2];
    assign bus.WE_S5     = s5[3];
endmodule

// File: tb/tb_lane_sensor_encoder.sv
// Scoreboard bench for lane_sensor_encoder (CNT_W=4, EXT_THRESH=5,
// DEB_CYCLES=3). Stimulus pushes the expected output snapshot and the cycle
// it must appear on; the monitor pops on every observed output change.
module tb_lane_sensor_encoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lane_sensor_encoder_if #(.CNT_W(4)) bus ();

    lane_sensor_encoder #(
        .CNT_W      (4),
        .EXT_THRESH (5),
        .DEB_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  ovf;
        logic [3:0]  s1;
        logic [3:0]  s5;
    } snap_t;

    typedef struct packed {
        snap_t s;
        int    cyc;
    } item_t;

    item_t          sb[$];
    logic [3:0][3:0] ecnt = '0;
    logic [3:0]     eovf = '0;
    bit             mon_en = 0;
    bit             done = 0;
    bit             first = 1;
    snap_t          prev = '0;
    int             checks = 0;
    int             failures = 0;

    function automatic snap_t mk(input logic [3:0][3:0] c, input logic [3:0] o);
        snap_t r;
        r.cnt = c;
        r.ovf = o;
        for (int i = 0; i < 4; i++) begin
            r.s1[i] = (c[i] != 4'd0);
            r.s5[i] = (c[i] >= 4'd5);
        end
        return r;
    endfunction

    function automatic snap_t obs();
        snap_t r;
        r.cnt = bus.queue_cnt;
        r.ovf = bus.ovf;
        r.s1  = {bus.WE_S1, bus.EW_S1, bus.SN_S1, bus.NS_S1};
        r.s5  = {bus.WE_S5, bus.EW_S5, bus.SN_S5, bus.NS_S5};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares on the first enabled cycle and on every output change.
    always @(negedge clk) begin
        snap_t o;
        item_t e;
        o = obs();
        if (done) begin
            chk("pending_expect", 32'(sb.size()), 32'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (mon_en && (first || o != prev)) begin
            first = 0;
            prev  = o;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_change actual=%0h required=%0h (cycle %0d)", o, prev, cyc);
            end else begin
                e = sb.pop_front();
                chk("queue_cnt", 32'(o.cnt), 32'(e.s.cnt));
                chk("ovf",       32'(o.ovf), 32'(e.s.ovf));
                chk("s1",        32'(o.s1),  32'(e.s.s1));
                chk("s5",        32'(o.s5),  32'(e.s.s5));
                chk("cycle",     32'(cyc),   32'(e.cyc));
            end
        end
    end

    // Drive a detector pattern; if chg, expect the new snapshot 6 edges later
    // (first sampling edge + DEB_CYCLES + 2).
    task automatic pulse(input logic [3:0] a, input logic [3:0] d,
                         input logic [3:0] ls, input int hold, input bit chg);
        bus.light_signal = ls;
        @(posedge clk); #1;
        if (chg) sb.push_back('{s: mk(ecnt, eovf), cyc: cyc + 6});
        bus.arr_raw = a;
        bus.dep_raw = d;
        repeat (hold) @(posedge clk);
        #1;
        bus.arr_raw = '0;
        bus.dep_raw = '0;
        repeat (8) @(posedge clk);
        #1;
        bus.light_signal = '0;
    endtask

    initial begin
        bus.arr_raw      = '0;
        bus.dep_raw      = '0;
        bus.light_signal = '0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{s: mk('0, '0), cyc: cyc});
        mon_en = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // single NS arrival held 10 cycles
        ecnt[0] = 4'd1; pulse(4'b0001, 4'b0000, 4'd0, 10, 1);
        // 2-cycle EW glitch: filtered out
        pulse(4'b0100, 4'b0000, 4'd0, 2, 0);
        // five SN arrivals, S5 on the fifth
        for (int k = 1; k <= 5; k++) begin
            ecnt[1] = 4'(k); pulse(4'b0010, 4'b0000, 4'd0, 6, 1);
        end
        // SN departure while SN green
        ecnt[1] = 4'd4; pulse(4'b0000, 4'b0010, 4'd3, 6, 1);
        // WE: arrival, departure on NS green ignored, on WE green applied
        ecnt[3] = 4'd1; pulse(4'b1000, 4'b0000, 4'd0, 6, 1);
        pulse(4'b0000, 4'b1000, 4'd1, 6, 0);
        ecnt[3] = 4'd0; pulse(4'b0000, 4'b1000, 4'd7, 6, 1);
        // NS up to 3, then simultaneous arrival + valid departure
        ecnt[0] = 4'd2; pulse(4'b0001, 4'b0000, 4'd0, 6, 1);
        ecnt[0] = 4'd3; pulse(4'b0001, 4'b0000, 4'd0, 6, 1);
        pulse(4'b0001, 4'b0001, 4'd1, 6, 0);
        // EW departure at count 0
        pulse(4'b0000, 4'b0100, 4'd5, 6, 0);
        // arrivals on all four lanes in one cycle
        ecnt[0] = 4'd4; ecnt[1] = 4'd5; ecnt[2] = 4'd1; ecnt[3] = 4'd1;
        pulse(4'b1111, 4'b0000, 4'd0, 6, 1);
        // NS to saturation, then one more sets ovf
        for (int k = 5; k <= 15; k++) begin
            ecnt[0] = 4'(k); pulse(4'b0001, 4'b0000, 4'd0, 6, 1);
        end
        eovf[0] = 1'b1; pulse(4'b0001, 4'b0000, 4'd0, 6, 1);
        // one-cycle reset clears everything
        @(posedge clk); #1;
        ecnt = '0; eovf = '0;
        sb.push_back('{s: mk('0, '0), cyc: cyc});
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        done = 1;
    end
endmodule
